// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - icache request/response, redirect and IF/ID signals of the fetch stage
// FETCH_PERF_EN adds the perf_fetch/perf_wait counters to the bundle.
interface inst_fetch_if;
    logic        ic_rvalid;
    logic [31:0] ic_raddr;
    logic        ic_rready;
    logic [31:0] ic_rdata;
    logic        id_stall;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_wait;

    modport master (
        output ic_rvalid, ic_raddr, id_valid, id_pc, id_inst, perf_fetch, perf_wait,
        input  ic_rready, ic_rdata, id_stall, redir_valid, redir_pc
    );
    modport slave (
        input  ic_rvalid, ic_raddr, id_valid, id_pc, id_inst, perf_fetch, perf_wait,
        output ic_rready, ic_rdata, id_stall, redir_valid, redir_pc
    );
`else
    modport master (
        output ic_rvalid, ic_raddr, id_valid, id_pc, id_inst,
        input  ic_rready, ic_rdata, id_stall, redir_valid, redir_pc
    );
    modport slave (
        input  ic_rvalid, ic_raddr, id_valid, id_pc, id_inst,
        output ic_rready, ic_rdata, id_stall, redir_valid, redir_pc
    );
`endif
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch front end: PC, chained icache requests, hold buffer, IF/ID
// Optional FETCH_PERF_EN: perf_fetch / perf_wait counters.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input logic          clk,
    input logic          rstn,
    inst_fetch_if.master bus
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] kill_pc_q, kill_pc_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;

    logic        rvalid;
    logic [31:0] raddr;
    logic [31:0] next_pc;
    logic        keep;
    logic        load_id;

    always_comb begin
        state_d   = state_q;
        req_pc_d  = req_pc_q;
        kill_d    = kill_q;
        kill_pc_d = kill_pc_q;
        rvalid    = 1'b0;
        raddr     = req_pc_q;
        keep      = 1'b0;
        next_pc   = bus.redir_valid ? bus.redir_pc : (kill_q ? kill_pc_q : req_pc_q + 32'd4);
        case (state_q)
            IDLE: begin
                rvalid = !hold_valid_q;
                if (bus.redir_valid) begin
                    raddr    = bus.redir_pc;
                    // Remember the target even when the hold buffer blocks the issue.
                    req_pc_d = bus.redir_pc;
                end
                if (rvalid) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!bus.ic_rready) begin
                    rvalid = 1'b1;
                    if (bus.redir_valid) begin
                        kill_d    = 1'b1;
                        kill_pc_d = bus.redir_pc;
                    end
                end else begin
                    keep     = !(bus.redir_valid || kill_q);
                    kill_d   = 1'b0;
                    req_pc_d = next_pc;
                    if (keep && bus.id_stall) begin
                        state_d = IDLE;
                    end else begin
                        rvalid = 1'b1;
                        raddr  = next_pc;
                    end
                end
            end
        endcase
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_inst_d  = hold_inst_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_inst_d    = id_inst_q;
        load_id      = 1'b0;
        if (bus.redir_valid) begin
            id_valid_d   = 1'b0;
            hold_valid_d = 1'b0;
        end else if (!bus.id_stall && hold_valid_q) begin
            id_valid_d   = 1'b1;
            id_pc_d      = hold_pc_q;
            id_inst_d    = hold_inst_q;
            hold_valid_d = 1'b0;
            load_id      = 1'b1;
        end else if (!bus.id_stall && keep) begin
            id_valid_d = 1'b1;
            id_pc_d    = req_pc_q;
            id_inst_d  = bus.ic_rdata;
            load_id    = 1'b1;
        end else if (!bus.id_stall) begin
            id_valid_d = 1'b0;
        end
        if (keep && bus.id_stall) begin
            hold_valid_d = 1'b1;
            hold_pc_d    = req_pc_q;
            hold_inst_d  = bus.ic_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            req_pc_q     <= RESET_PC;
            kill_q       <= 1'b0;
            kill_pc_q    <= 32'd0;
            hold_valid_q <= 1'b0;
            hold_pc_q    <= 32'd0;
            hold_inst_q  <= NOP_INST;
            id_valid_q   <= 1'b0;
            id_pc_q      <= 32'd0;
            id_inst_q    <= NOP_INST;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            kill_q       <= kill_d;
            kill_pc_q    <= kill_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_inst_q  <= hold_inst_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_inst_q    <= id_inst_d;
        end
    end

    assign bus.ic_rvalid = rvalid && rstn;
    assign bus.ic_raddr  = raddr;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_inst   = id_inst_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_wait_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_fetch_q <= 32'd0;
            perf_wait_q  <= 32'd0;
        end else begin
            if (load_id) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (state_q == WAIT && !bus.ic_rready) begin
                perf_wait_q <= perf_wait_q + 32'd1;
            end
        end
    end

    assign bus.perf_fetch = perf_fetch_q;
    assign bus.perf_wait  = perf_wait_q;
`else
    logic unused_load_id;
    assign unused_load_id = load_id;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch with icache model and program-order scoreboard
module tb_inst_fetch;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[31:16] ^ a[15:0], a[15:0]};
    endfunction

    // icache: captures a request when idle or on its own response cycle, answers after lat_cfg extra cycles
    logic        outst  = 1'b0;
    logic [31:0] c_addr = 32'd0;
    int          lat    = 0;
    int          lat_cfg = 0;
    logic        p_cap = 1'b0, p_rdy = 1'b0, p_rst = 1'b1;
    logic [31:0] p_addr = 32'd0;

    assign bus.ic_rready = outst && (lat == 0);
    assign bus.ic_rdata  = inst_of(c_addr);

    always begin
        @(negedge clk);
        #2;
        p_rst  = !rstn;
        p_cap  = bus.ic_rvalid && (!outst || bus.ic_rready);
        p_addr = bus.ic_raddr;
        p_rdy  = bus.ic_rready;
    end

    always @(posedge clk) begin
        if (p_rst) begin
            outst <= 1'b0;
        end else if (p_cap) begin
            outst  <= 1'b1;
            c_addr <= p_addr;
            lat    <= lat_cfg;
        end else if (p_rdy) begin
            outst <= 1'b0;
        end else if (outst && lat > 0) begin
            lat <= lat - 1;
        end
    end

    // Program-order scoreboard: each newly loaded IF/ID must be the next PC in flow and carry its memory word
    logic        m_rstn = 1'b1, m_redir = 1'b0, m_stall = 1'b0, m_valid = 1'b0;
    logic [31:0] m_pc = 32'd0, m_inst = 32'd0;
    logic [31:0] exp_pc = 32'd0;

    always begin
        @(negedge clk);
        #2;
        if (!rstn) begin
            check("rst_rvalid", {31'd0, bus.ic_rvalid}, 32'd0);
            if (!m_rstn) begin
                check("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
                check("rst_id_pc", bus.id_pc, 32'd0);
                check("rst_id_inst", bus.id_inst, 32'h0000_0013);
            end
            exp_pc = 32'd0;
        end else begin
            if (!m_rstn) begin
                check("post_rst_valid", {31'd0, bus.id_valid}, 32'd0);
            end else if (m_redir) begin
                check("redir_flush", {31'd0, bus.id_valid}, 32'd0);
            end else if (m_stall) begin
                check("stall_valid", {31'd0, bus.id_valid}, {31'd0, m_valid});
                check("stall_pc", bus.id_pc, m_pc);
                check("stall_inst", bus.id_inst, m_inst);
            end else if (bus.id_valid) begin
                check("flow_pc", bus.id_pc, exp_pc);
                check("flow_inst", bus.id_inst, inst_of(bus.id_pc));
                exp_pc = bus.id_pc + 32'd4;
            end
            if (outst && !bus.ic_rready) begin
                check("pending_rvalid", {31'd0, bus.ic_rvalid}, 32'd1);
                check("pending_raddr", bus.ic_raddr, c_addr);
            end
            if (bus.ic_rvalid) begin
                check("raddr_align", {30'd0, bus.ic_raddr[1:0]}, 32'd0);
            end
            if (bus.redir_valid) begin
                exp_pc = bus.redir_pc;
            end
        end
        m_rstn  = rstn;
        m_redir = bus.redir_valid;
        m_stall = bus.id_stall;
        m_valid = bus.id_valid;
        m_pc    = bus.id_pc;
        m_inst  = bus.id_inst;
    end

    // Leaves the bench at the negedge that releases reset (cycle 0 of a test).
    task automatic do_reset();
        rstn            = 1'b0;
        bus.id_stall    = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 32'd0;
        lat_cfg         = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        bus.id_stall    = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 32'd0;

        // back-to-back hits
        do_reset();
        #1;
        check("t1_c0_rvalid", {31'd0, bus.ic_rvalid}, 32'd1);
        check("t1_c0_raddr", bus.ic_raddr, 32'h0);
        check("t1_c0_id_valid", {31'd0, bus.id_valid}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1;
            check("t1_raddr", bus.ic_raddr, 32'(4 * k));
            if (k >= 2) begin
                check("t1_id_valid", {31'd0, bus.id_valid}, 32'd1);
                check("t1_id_pc", bus.id_pc, 32'(4 * (k - 2)));
            end
        end

        // stall on the 0x8 response
        do_reset();
        repeat (3) @(negedge clk);
        bus.id_stall = 1'b1;
        #1;
        check("t2_hold_rvalid", {31'd0, bus.ic_rvalid}, 32'd0);
        @(negedge clk);
        bus.id_stall = 1'b0;
        #1;
        check("t2_drain_rvalid", {31'd0, bus.ic_rvalid}, 32'd0);
        check("t2_held_pc", bus.id_pc, 32'h4);
        @(negedge clk);
        #1;
        check("t2_hold_pc", bus.id_pc, 32'h8);
        check("t2_hold_valid", {31'd0, bus.id_valid}, 32'd1);
        check("t2_refetch", bus.ic_raddr, 32'hC);
        @(negedge clk);
        #1;
        check("t2_gap", {31'd0, bus.id_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("t2_resume_pc", bus.id_pc, 32'hC);

        // redirect while a slow request is outstanding
        do_reset();
        lat_cfg         = 10;
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h40;
        #1;
        check("t3_issue_raddr", bus.ic_raddr, 32'h40);
        @(negedge clk);
        bus.redir_valid = 1'b0;
        repeat (2) @(negedge clk);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h100;
        lat_cfg         = 0;
        #1;
        check("t3_kill_raddr", bus.ic_raddr, 32'h40);
        for (int c = 4; c <= 10; c++) begin
            @(negedge clk);
            bus.redir_valid = 1'b0;
        end
        #1;
        check("t3_c10_rready", {31'd0, bus.ic_rready}, 32'd0);
        @(negedge clk);
        #1;
        check("t3_c11_rready", {31'd0, bus.ic_rready}, 32'd1);
        check("t3_c11_raddr", bus.ic_raddr, 32'h100);
        @(negedge clk);
        #1;
        check("t3_c12_valid", {31'd0, bus.id_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("t3_c13_valid", {31'd0, bus.id_valid}, 32'd1);
        check("t3_c13_pc", bus.id_pc, 32'h100);

        // redirect on the response cycle
        do_reset();
        @(negedge clk);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h200;
        #1;
        check("t4_rready", {31'd0, bus.ic_rready}, 32'd1);
        check("t4_raddr", bus.ic_raddr, 32'h200);
        @(negedge clk);
        bus.redir_valid = 1'b0;
        #1;
        check("t4_dropped", {31'd0, bus.id_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("t4_pc", bus.id_pc, 32'h200);
        check("t4_inst", bus.id_inst, 32'h0200_0200);

        // reset while the hold buffer is full
        do_reset();
        repeat (3) @(negedge clk);
        bus.id_stall = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("t5_rst_rvalid", {31'd0, bus.ic_rvalid}, 32'd0);
        @(negedge clk);
        #1;
        check("t5_id_valid", {31'd0, bus.id_valid}, 32'd0);
        check("t5_id_inst", bus.id_inst, 32'h0000_0013);
        bus.id_stall = 1'b0;
        rstn = 1'b1;
        #1;
        check("t5_first_rvalid", {31'd0, bus.ic_rvalid}, 32'd1);
        check("t5_first_raddr", bus.ic_raddr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t5_first_pc", bus.id_pc, 32'h0);

`ifdef FETCH_PERF_EN
        do_reset();
        #1;
        check("perf_fetch_rst", bus.perf_fetch, 32'd0);
        check("perf_wait_rst", bus.perf_wait, 32'd0);
        repeat (4) @(negedge clk);
        lat_cfg = 5;
        @(negedge clk);
        lat_cfg = 0;
        repeat (6) @(negedge clk);
        #1;
        check("perf_fetch", bus.perf_fetch, 32'd5);
        check("perf_wait", bus.perf_wait, 32'd5);
`endif

        repeat (3) @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch front end of the pipelined core. It owns the PC, issues read requests to the instruction cache over the rvalid/rready/raddr/rdata handshake, and chains back-to-back requests so a hitting cache sustains one instruction per cycle. It absorbs decode back-pressure in a one-entry hold buffer, kills in-flight fetches on EX-stage redirects, and drives the IF/ID register consumed by decode. The icache `stall` input is tied low at top level.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, value of id_inst at reset
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low; clock clk
- ic_rvalid  out  1  request valid to icache
- ic_raddr  out  32  request address to icache (combinational)
- ic_rready  in  1  icache response strobe; ic_rdata valid this cycle for the outstanding request
- ic_rdata  in  32  instruction from icache
- id_stall  in  1  decode cannot accept a new instruction this cycle
- redir_valid  in  1  one-cycle redirect pulse from EX
- redir_pc  in  32  redirect target, word aligned
- id_valid  out  1  IF/ID holds a live instruction
- id_pc  out  32  PC of id_inst
- id_inst  out  32  instruction to decode

## Operation
- Registers: req_pc (address of outstanding or next request), state, kill, kill_pc, hold_valid/hold_pc/hold_inst, IF/ID triple.
- States: IDLE (nothing outstanding), WAIT (icache has captured req_pc, response pending).
- IDLE: ic_rvalid = !hold_valid; ic_raddr = redir_valid ? redir_pc : req_pc. If ic_rvalid -> WAIT, req_pc <= ic_raddr.
- WAIT, ic_rready=0: ic_rvalid=1, ic_raddr=req_pc. redir_valid -> kill<=1, kill_pc<=redir_pc.
- WAIT, ic_rready=1 (response cycle): next = redir_valid ? redir_pc : kill ? kill_pc : req_pc+4. Response discarded if redir_valid|kill; kill<=0.
  - Kept and !id_stall: IF/ID <= {1, req_pc, ic_rdata}; chain: ic_rvalid=1, ic_raddr=next, req_pc<=next, stay WAIT.
  - Kept and id_stall: hold <= {1, req_pc, ic_rdata}; ic_rvalid=0, req_pc<=next -> IDLE.
  - Discarded: always chain with next (ic_rvalid=1), stay WAIT.
- IF/ID update, priority order: redir_valid -> id_valid<=0, hold_valid<=0; else !id_stall and hold_valid -> IF/ID<=hold, hold_valid<=0; else !id_stall and kept response -> as above; else !id_stall -> id_valid<=0; id_stall -> unchanged.
- PC arithmetic 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000; bits [1:0] of addresses always 0.
- Reset mid-WAIT: state IDLE, kill 0, hold empty; any late ic_rready while in IDLE is ignored.

## Timing
- While rstn=0: ic_rvalid=0, id_valid=0, id_pc=0, id_inst=NOP_INST, req_pc=RESET_PC, state IDLE.
- First cycle after reset: ic_rvalid=1, ic_raddr=RESET_PC.
- Hit latency: issue cycle N, ic_rready N+1, id_valid N+2. Chained hits: one id_valid per cycle.
- Redirect at cycle N: id_valid=0 at N+1; first fetch of target issued at N (IDLE or response cycle) or on the response cycle of the killed request.
- Hold drains the first cycle id_stall=0, with no new request issued in that cycle; refetch at req_pc then resumes (IDLE issues again once hold empties).
- ic_raddr is stable whenever ic_rvalid=1 and ic_rready=0.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetch (32, count of instructions loaded into IF/ID) and perf_wait (32, cycles in WAIT with ic_rready=0); both cleared by rstn, wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- RESET_PC=0x0, ic_rready=1 every cycle from cycle 1 -> id_pc 0x0,0x4,0x8,0xC on consecutive cycles from cycle 2, ic_raddr leads by one.
- id_stall=1 on response for 0x8 -> hold captures 0x8, ic_rvalid=0; id_stall=0 -> id_pc=0x8 next cycle, then fetch resumes at 0xC.
- Request 0x40 outstanding, ic_rready low 10 cycles, redir to 0x100 at cycle 3 -> 0x40 response discarded, ic_raddr=0x100 that cycle, next id_pc=0x100.
- redir_valid with ic_rready same cycle, redir_pc=0x200 -> response dropped, ic_raddr=0x200 that cycle, id_valid=0 next cycle.
- rstn low during WAIT with hold_valid=1 -> id_valid=0, id_inst=0x00000013, first request after release at RESET_PC.
- FETCH_PERF_EN: 4 hits, then 1 miss with 5 wait cycles -> perf_fetch=5, perf_wait=5.
